// File: rtl/serdes_pattern_pkg.sv
// Shared definitions for the SERDES pattern generators and the receive-side pattern checker:
// pattern modes, PRBS31 taps, the default constant pattern and the checker lock states.
package serdes_pattern_pkg;

    localparam logic [1:0] MODE_CNT    = 2'b00;
    localparam logic [1:0] MODE_PRBS   = 2'b01;
    localparam logic [1:0] MODE_CONST  = 2'b10;
    localparam logic [1:0] MODE_CONSTB = 2'b11;

    // x^31 + x^28 + 1: b[n] = b[n-31] ^ b[n-28]
    localparam int PRBS_TAP_A = 31;
    localparam int PRBS_TAP_B = 28;

    localparam logic [127:0] CONST_PAT_DEFAULT = {32{4'hA}};

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/prbs31_predict.sv
// Combinational PRBS31 predictor: maps the last 31 stream bits (hist[0] newest) to the
// next DW bits, pred[DW-1] earliest in time. Shared with the transmit-side PRBS generator.
module prbs31_predict
    import serdes_pattern_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic [PRBS_TAP_A-1:0] hist,
    output logic [DW-1:0]         pred
);

    // Bit p of the extended vector depends on bits 31 and 28 positions earlier in time.
    function automatic logic [DW-1:0] predict(input logic [PRBS_TAP_A-1:0] h);
        logic [DW+PRBS_TAP_A-1:0] s;
        s = {h, {DW{1'b0}}};
        for (int p = DW - 1; p >= 0; p--) begin
            s[p] = s[p+PRBS_TAP_A] ^ s[p+PRBS_TAP_B];
        end
        return s[DW-1:0];
    endfunction

    assign pred = predict(hist);

endmodule

// File: rtl/pattern_checker.sv
// Receive-side pattern checker: hunts for lock on counter/PRBS31/const/const_bar data and
// counts word and bit errors while locked. FIRST_ERR_CAPTURE_EN adds first-error capture.
module pattern_checker
    import serdes_pattern_pkg::*;
#(
    parameter int             DW         = 128,
    parameter logic [DW-1:0]  CONST_PAT  = CONST_PAT_DEFAULT,
    parameter int             LOCK_CNT   = 16,
    parameter int             UNLOCK_CNT = 8,
    parameter int             CNT_W      = 32
) (
    input  logic             clk160,
    input  logic             rst,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    input  logic [1:0]       sel,
    input  logic             clear,
    output logic             locked,
    output logic             err_word,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_word_cnt,
    output logic [CNT_W-1:0] err_bit_cnt
`ifdef FIRST_ERR_CAPTURE_EN
    ,
    output logic [DW-1:0]    first_err_vec,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
`endif
);

    localparam int RUN_W = $clog2(LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT) + 1;
    localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
    localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_CNT - 1);

    state_t           state;
    logic [1:0]       sel_q;
    logic [DW-1:0]    seed;
    logic             seed_ok;
    logic [RUN_W-1:0] match_run;
    logic [RUN_W-1:0] err_run;
    logic [DW-1:0]    mis_q;
    logic             err_q;

    logic [DW-1:0]    pred;
    logic [DW-1:0]    expected;
    logic [DW-1:0]    mis;
    logic             errored;
    logic             sel_chg;
    logic             compare;
    logic             count_word;
    logic             count_err;

    prbs31_predict #(.DW(DW)) u_predict (
        .hist (seed[PRBS_TAP_A-1:0]),
        .pred (pred)
    );

    always_comb begin
        // NOTE: default assignment ahead of the case keeps expected fully driven (no latch).
        expected = ~CONST_PAT;
        unique case (sel_q)
            MODE_CNT:    expected = seed + DW'(1);
            MODE_PRBS:   expected = pred;
            MODE_CONST:  expected = CONST_PAT;
            MODE_CONSTB: expected = ~CONST_PAT;
        endcase
    end

    assign mis        = din ^ expected;
    assign errored    = |mis;
    assign sel_chg    = (sel != sel_q);
    // A word after a sel change is dropped; the first word after entering HUNT only seeds.
    assign compare    = din_valid & ~sel_chg & seed_ok;
    assign count_word = compare & (state == LOCKED);
    assign count_err  = count_word & errored;
    assign locked     = (state == LOCKED);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // NOTE: mis_q is a datapath register qualified by err_q, so it is left out of reset.
    always_ff @(posedge clk160) begin
        mis_q <= mis;
    end

    always_ff @(posedge clk160) begin
        if (rst) begin
            state     <= HUNT;
            sel_q     <= MODE_CNT;
            seed      <= '0;
            seed_ok   <= 1'b0;
            match_run <= '0;
            err_run   <= '0;
            err_word  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sel_q    <= sel;
            err_word <= count_err;
            err_q    <= count_err & ~clear;
            if (sel_chg) begin
                state     <= HUNT;
                seed_ok   <= 1'b0;
                match_run <= '0;
                err_run   <= '0;
            end else if (din_valid) begin
                seed    <= din;
                seed_ok <= 1'b1;
                if (seed_ok && state == HUNT) begin
                    if (errored) begin
                        match_run <= '0;
                    end else if (match_run == LOCK_LAST) begin
                        state     <= LOCKED;
                        match_run <= '0;
                        err_run   <= '0;
                    end else begin
                        match_run <= match_run + 1'b1;
                    end
                end else if (seed_ok) begin
                    if (!errored) begin
                        err_run <= '0;
                    end else if (err_run == UNLOCK_LAST) begin
                        state   <= HUNT;
                        seed_ok <= 1'b0;
                        err_run <= '0;
                    end else begin
                        err_run <= err_run + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk160) begin
        if (rst || clear) begin
            word_cnt     <= '0;
            err_word_cnt <= '0;
            err_bit_cnt  <= '0;
        end else begin
            if (count_word) word_cnt     <= sat_add(word_cnt, CNT_W'(1));
            if (count_err)  err_word_cnt <= sat_add(err_word_cnt, CNT_W'(1));
            if (err_q)      err_bit_cnt  <= sat_add(err_bit_cnt, CNT_W'($countones(mis_q)));
        end
    end

`ifdef FIRST_ERR_CAPTURE_EN
    // first_err_idx holds word_cnt as it stood before the errored word was counted.
    always_ff @(posedge clk160) begin
        if (rst || clear) begin
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            first_err_idx <= '0;
        end else if (count_err && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_vec <= mis;
            first_err_idx <= word_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pattern_checker.sv
// Self-checking bench for pattern_checker: scoreboard of per-word err_word/locked
// expectations plus counter checks; a CNT_W=8 instance covers saturation.
module tb_pattern_checker;
    import serdes_pattern_pkg::*;

    localparam logic [127:0] CP = CONST_PAT_DEFAULT;

    logic         clk160 = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] din = '0;
    logic         din_valid = 1'b0;
    logic [1:0]   sel = 2'b00;
    logic         clear = 1'b0;

    logic         locked, err_word;
    logic [31:0]  word_cnt, err_word_cnt, err_bit_cnt;
    logic         locked8, err_word8;
    logic [7:0]   word_cnt8, err_word_cnt8, err_bit_cnt8;
`ifdef FIRST_ERR_CAPTURE_EN
    logic [127:0] first_err_vec, first_err_vec8;
    logic [31:0]  first_err_idx;
    logic [7:0]   first_err_idx8;
    logic         first_err_vld, first_err_vld8;
`endif

    pattern_checker dut (
        .clk160(clk160), .rst(rst), .din(din), .din_valid(din_valid), .sel(sel),
        .clear(clear), .locked(locked), .err_word(err_word), .word_cnt(word_cnt),
        .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_vec(first_err_vec), .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld)
`endif
    );

    pattern_checker #(.CNT_W(8)) dut8 (
        .clk160(clk160), .rst(rst), .din(din), .din_valid(din_valid), .sel(sel),
        .clear(clear), .locked(locked8), .err_word(err_word8), .word_cnt(word_cnt8),
        .err_word_cnt(err_word_cnt8), .err_bit_cnt(err_bit_cnt8)
`ifdef FIRST_ERR_CAPTURE_EN
        , .first_err_vec(first_err_vec8), .first_err_idx(first_err_idx8),
        .first_err_vld(first_err_vld8)
`endif
    );

    always #3 clk160 = ~clk160;

    typedef struct {
        logic err;
        logic lk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Serial PRBS31 reference: h[0] newest bit, h[30] is b[n-31], h[27] is b[n-28].
    function automatic logic [127:0] prbs_next(input logic [30:0] hist);
        logic [30:0]  h;
        logic [127:0] w;
        logic         b;
        h = hist;
        w = '0;
        for (int i = 127; i >= 0; i--) begin
            b    = h[30] ^ h[27];
            w[i] = b;
            h    = {h[29:0], b};
        end
        return w;
    endfunction

    // Push the expectation for this word, clock it in, then pop and compare after the edge.
    task automatic drive(input logic [127:0] d, input logic v, input logic e_err, input logic e_lk);
        exp_t e;
        din       = d;
        din_valid = v;
        e.err     = e_err;
        e.lk      = e_lk;
        sb.push_back(e);
        @(posedge clk160);
        #1;
        e = sb.pop_front();
        checks++;
        if (err_word !== e.err) begin
            failures++;
            $display("FAIL sb_err_word t=%0t got=%b exp=%b", $time, err_word, e.err);
        end
        checks++;
        if (locked !== e.lk) begin
            failures++;
            $display("FAIL sb_locked t=%0t got=%b exp=%b", $time, locked, e.lk);
        end
        clear = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive('0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({word_cnt, err_word_cnt, err_bit_cnt} !== 96'd0) begin
            failures++;
            $display("FAIL reset_cnts got=%h exp=0", {word_cnt, err_word_cnt, err_bit_cnt});
        end
`ifdef FIRST_ERR_CAPTURE_EN
        checks++;
        if (first_err_vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_vld got=%b exp=0", first_err_vld);
        end
`endif
    endtask

    task automatic test_counter();
        logic [127:0] w;
        sel = MODE_CNT;
        for (int k = 0; k <= 116; k++) drive(128'(k), 1'b1, 1'b0, k >= 16);
        checks++;
        if (word_cnt !== 32'd100 || err_word_cnt !== 32'd0 || err_bit_cnt !== 32'd0) begin
            failures++;
            $display("FAIL cnt_clean got=%0d/%0d/%0d exp=100/0/0", word_cnt, err_word_cnt, err_bit_cnt);
        end
        drive(128'(117) ^ 128'h20, 1'b1, 1'b1, 1'b1);
        checks++;
        if (err_word_cnt !== 32'd1 || err_bit_cnt !== 32'd0) begin
            failures++;
            $display("FAIL cnt_flip1 got=%0d/%0d exp=1/0", err_word_cnt, err_bit_cnt);
        end
        drive(128'(118), 1'b1, 1'b1, 1'b1);
        checks++;
        if (err_word_cnt !== 32'd2 || err_bit_cnt !== 32'd1) begin
            failures++;
            $display("FAIL cnt_flip2 got=%0d/%0d exp=2/1", err_word_cnt, err_bit_cnt);
        end
        drive(128'(119), 1'b1, 1'b0, 1'b1);
        checks++;
        if (err_bit_cnt !== 32'd2 || word_cnt !== 32'd103) begin
            failures++;
            $display("FAIL cnt_flip3 got=%0d/%0d exp=2/103", err_bit_cnt, word_cnt);
        end
`ifdef FIRST_ERR_CAPTURE_EN
        checks++;
        if (first_err_vld !== 1'b1 || first_err_vec !== 128'h20 || first_err_idx !== 32'd100) begin
            failures++;
            $display("FAIL first_err got=%b/%h/%0d exp=1/20/100", first_err_vld, first_err_vec, first_err_idx);
        end
`endif
        // Counter wrap: all-ones is followed by zero.
        w = '1;
        w[0] = 1'b0;
        drive(w, 1'b1, 1'b1, 1'b1);
        drive('1, 1'b1, 1'b0, 1'b1);
        drive('0, 1'b1, 1'b0, 1'b1);
        drive(128'd1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_prbs();
        logic [30:0]  hist;
        logic [127:0] w, w_bad, flip;
        int           diff;
        sel = MODE_PRBS;
        drive('0, 1'b1, 1'b0, 1'b0);
        hist = 31'h7FFF_FFFF;
        for (int k = 0; k <= 19; k++) begin
            w    = prbs_next(hist);
            hist = w[30:0];
            if (k == 17) clear = 1'b1;
            drive(w, 1'b1, 1'b0, k >= 16);
        end
        flip = '0;
        flip[100] = 1'b1;
        flip[20]  = 1'b1;
        flip[3]   = 1'b1;
        w     = prbs_next(hist);
        w_bad = w ^ flip;
        drive(w_bad, 1'b1, 1'b1, 1'b1);
        hist = w[30:0];
        w    = prbs_next(hist);
        diff = $countones(w ^ prbs_next(w_bad[30:0]));
        drive(w, 1'b1, diff != 0, 1'b1);
        hist = w[30:0];
        drive(prbs_next(hist), 1'b1, 1'b0, 1'b1);
        checks++;
        if (err_bit_cnt !== 32'(3 + diff) || err_word_cnt !== 32'd2 || word_cnt !== 32'd5) begin
            failures++;
            $display("FAIL prbs_cnts got=%0d/%0d/%0d exp=%0d/2/5", err_bit_cnt, err_word_cnt, word_cnt, 3 + diff);
        end
    endtask

    task automatic test_const_bar_unlock();
        sel = MODE_CONSTB;
        drive(~CP, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 16; k++) drive(~CP, 1'b1, 1'b0, k == 16);
        clear = 1'b1;
        drive(~CP, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) drive(CP, 1'b1, 1'b1, k < 7);
        checks++;
        if (err_word_cnt !== 32'd8 || word_cnt !== 32'd8 || err_bit_cnt !== 32'd896) begin
            failures++;
            $display("FAIL constb_unlock got=%0d/%0d/%0d exp=8/8/896", err_word_cnt, word_cnt, err_bit_cnt);
        end
        drive('0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_bit_cnt !== 32'd1024) begin
            failures++;
            $display("FAIL constb_bits got=%0d exp=1024", err_bit_cnt);
        end
    endtask

    task automatic test_sel_switch();
        int n;
        sel = MODE_CNT;
        drive('0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 17; k++) drive(128'(k), 1'b1, 1'b0, k >= 16);
        sel = MODE_CONST;
        drive(128'h5, 1'b1, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 33; i++) begin
            if (i % 2 == 0) begin
                drive(CP, 1'b1, 1'b0, n == 16);
                n++;
            end else begin
                drive({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (word_cnt !== 32'd9 || err_word_cnt !== 32'd8 || err_bit_cnt !== 32'd1024) begin
            failures++;
            $display("FAIL switch_retain got=%0d/%0d/%0d exp=9/8/1024", word_cnt, err_word_cnt, err_bit_cnt);
        end
        clear = 1'b1;
        drive(CP, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({word_cnt, err_word_cnt, err_bit_cnt} !== 96'd0) begin
            failures++;
            $display("FAIL switch_clear got=%h exp=0", {word_cnt, err_word_cnt, err_bit_cnt});
        end
    endtask

    task automatic test_saturation_and_reset();
        sel = MODE_CONSTB;
        drive(~CP, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 16; k++) drive(~CP, 1'b1, 1'b0, k == 16);
        clear = 1'b1;
        drive(~CP, 1'b1, 1'b0, 1'b1);
        drive(CP, 1'b1, 1'b1, 1'b1);
        drive(CP, 1'b1, 1'b1, 1'b1);
        drive('0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err_bit_cnt !== 32'd256 || err_bit_cnt8 !== 8'hFF || err_word_cnt8 !== 8'd2) begin
            failures++;
            $display("FAIL sat_bits got=%0d/%h/%0d exp=256/ff/2", err_bit_cnt, err_bit_cnt8, err_word_cnt8);
        end
        drive(CP, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        drive(CP, 1'b1, 1'b0, 1'b0);
        drive('0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({word_cnt, err_word_cnt, err_bit_cnt} !== 96'd0 ||
            {word_cnt8, err_word_cnt8, err_bit_cnt8, locked8, err_word8} !== 26'd0) begin
            failures++;
            $display("FAIL rst_mid got=%h/%h exp=0/0", {word_cnt, err_word_cnt, err_bit_cnt},
                     {word_cnt8, err_word_cnt8, err_bit_cnt8, locked8, err_word8});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_counter();
        test_prbs();
        test_const_bar_unlock();
        test_sel_switch();
        test_saturation_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
